// File: rtl/rawrec_stream_ctrl.sv
// Pairs left/right audio samples into stereo frames and buffers them in a FIFO.
// It then streams each frame to the UART byte by byte, putting a sync marker in
// front of a frame at regular intervals.
// Define RAWREC_STATUS_BYTE_EN to append the snapshotted overrun count after the sync marker.
module rawrec_stream_ctrl #(
    parameter int          FIFO_DEPTH    = 16,
    parameter int          SYNC_INTERVAL = 256,
    parameter logic [7:0]  SYNC_BYTE0    = 8'hA5,
    parameter logic [7:0]  SYNC_BYTE1    = 8'h5A
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          arm,
    input  logic                          smp_valid,
    input  logic                          smp_ch,
    input  logic [15:0]                   smp_data,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic [7:0]                    overrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(SYNC_INTERVAL) + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC0 = 3'd1,
        ST_SYNC1 = 3'd2,
`ifdef RAWREC_STATUS_BYTE_EN
        ST_STAT  = 3'd3,
`endif
        ST_LH    = 3'd4,
        ST_LL    = 3'd5,
        ST_RH    = 3'd6,
        ST_RL    = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic            arm_q;
    logic            pend_q, pend_d;
    logic [15:0]     left_q, left_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      ovr_q, ovr_d;
    logic [31:0]     frame_q, frame_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sync_due_q, sync_due_d;
    logic [7:0]      stat_q, stat_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            busy_q, busy_d;
    logic [31:0]     mem_q [FIFO_DEPTH];

    logic            xfer_s, fifo_empty_s, fifo_full_s, rl_done_s, due_now_s;
    logic            push_req_s, push_s, pop_s, drop_s, enter_sync0_s;
    logic [CW-1:0]   cnt_inc_s;

    // Handshake, FIFO arbitration and the sync decision made when a frame completes.
    always_comb begin
        xfer_s       = tx_valid_q & tx_ready;
        fifo_empty_s = (level_q == LW'(0));
        fifo_full_s  = (level_q == LW'(FIFO_DEPTH));
        rl_done_s    = (state_q == ST_RL) & xfer_s;
        cnt_inc_s    = cnt_q + CW'(1);
        due_now_s    = sync_due_q | (rl_done_s & (cnt_inc_s == CW'(SYNC_INTERVAL)));
        push_req_s   = arm & smp_valid & smp_ch & pend_q;
        pop_s        = ~fifo_empty_s & ((state_q == ST_IDLE) | rl_done_s);
        push_s       = push_req_s & (~fifo_full_s | pop_s);
        drop_s       = push_req_s & fifo_full_s & ~pop_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every state except IDLE advances only on a byte transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = fifo_empty_s ? ST_IDLE : (due_now_s ? ST_SYNC0 : ST_LH);
            ST_SYNC0: state_d = xfer_s ? ST_SYNC1 : ST_SYNC0;
`ifdef RAWREC_STATUS_BYTE_EN
            ST_SYNC1: state_d = xfer_s ? ST_STAT : ST_SYNC1;
            ST_STAT:  state_d = xfer_s ? ST_LH : ST_STAT;
`else
            ST_SYNC1: state_d = xfer_s ? ST_LH : ST_SYNC1;
`endif
            ST_LH:    state_d = xfer_s ? ST_LL : ST_LH;
            ST_LL:    state_d = xfer_s ? ST_RH : ST_LL;
            ST_RH:    state_d = xfer_s ? ST_RL : ST_RH;
            ST_RL: begin
                if (xfer_s) begin
                    state_d = fifo_empty_s ? ST_IDLE : (due_now_s ? ST_SYNC0 : ST_LH);
                end else begin
                    state_d = ST_RL;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sample pairing, FIFO bookkeeping, overrun counting and sync scheduling.
    always_comb begin
        left_d = left_q;
        pend_d = pend_q;
        if (!arm) begin
            pend_d = 1'b0;
        end else if (smp_valid && !smp_ch) begin
            pend_d = 1'b1;
            left_d = smp_data;
        end else if (push_req_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end

        wptr_d  = push_s ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop_s ? rptr_q + AW'(1) : rptr_q;
        level_d = level_q + LW'(push_s) - LW'(pop_s);
        ovr_d   = (drop_s && (ovr_q != 8'hFF)) ? ovr_q + 8'd1 : ovr_q;
        frame_d = pop_s ? mem_q[rptr_q] : frame_q;

        enter_sync0_s = (state_d == ST_SYNC0) & (state_q != ST_SYNC0);
        cnt_d      = rl_done_s ? cnt_inc_s : cnt_q;
        sync_due_d = due_now_s;
        if (enter_sync0_s) begin
            cnt_d      = CW'(0);
            sync_due_d = 1'b0;
        end else begin
            cnt_d      = cnt_d;
        end
        // A fresh capture session always starts with a sync marker.
        if (arm && !arm_q) begin
            sync_due_d = 1'b1;
        end else begin
            sync_due_d = sync_due_d;
        end
        stat_d = enter_sync0_s ? ovr_q : stat_q;
    end

    // Output byte selection from the state being entered, so outputs come from flops.
    always_comb begin
        tx_valid_d = (state_d != ST_IDLE);
        busy_d     = tx_valid_d | (level_d != LW'(0));
        case (state_d)
            ST_SYNC0: tx_data_d = SYNC_BYTE0;
            ST_SYNC1: tx_data_d = SYNC_BYTE1;
`ifdef RAWREC_STATUS_BYTE_EN
            ST_STAT:  tx_data_d = stat_d;
`endif
            ST_LH:    tx_data_d = frame_d[31:24];
            ST_LL:    tx_data_d = frame_d[23:16];
            ST_RH:    tx_data_d = frame_d[15:8];
            ST_RL:    tx_data_d = frame_d[7:0];
            default:  tx_data_d = 8'h00;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            arm_q      <= 1'b0;
            pend_q     <= 1'b0;
            left_q     <= 16'h0000;
            wptr_q     <= AW'(0);
            rptr_q     <= AW'(0);
            level_q    <= LW'(0);
            ovr_q      <= 8'h00;
            frame_q    <= 32'h0000_0000;
            cnt_q      <= CW'(0);
            sync_due_q <= 1'b1;
            stat_q     <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            arm_q      <= arm;
            pend_q     <= pend_d;
            left_q     <= left_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            ovr_q      <= ovr_d;
            frame_q    <= frame_d;
            cnt_q      <= cnt_d;
            sync_due_q <= sync_due_d;
            stat_q     <= stat_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Frame storage; contents need no reset because the level counter qualifies them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wptr_q] <= {left_q, smp_data};
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign overrun_cnt = ovr_q;
    assign fifo_level  = level_q;

endmodule

// File: tb/tb_rawrec_stream_ctrl.sv
// Directed bench for rawrec_stream_ctrl (FIFO_DEPTH=16, SYNC_INTERVAL=2).
// Expected byte streams are built from hand-written frame values.
module tb_rawrec_stream_ctrl;

    localparam int DEPTH = 16;
    localparam int SI    = 2;
`ifdef RAWREC_STATUS_BYTE_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        arm = 1'b0;
    logic        smp_valid = 1'b0;
    logic        smp_ch = 1'b0;
    logic [15:0] smp_data = 16'h0000;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic [7:0]  overrun_cnt;
    logic [4:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    logic hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    rawrec_stream_ctrl #(.FIFO_DEPTH(DEPTH), .SYNC_INTERVAL(SI)) dut (
        .clk(clk), .nreset(nreset), .arm(arm), .smp_valid(smp_valid), .smp_ch(smp_ch),
        .smp_data(smp_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .overrun_cnt(overrun_cnt), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte capture and hold-stability monitor; inputs only change just after posedge.
    always @(negedge clk) begin
        cyc++;
        if (hold_v) begin
            check("hold_valid", tx_valid, 1'b1);
            check("hold_data", tx_data, hold_d);
        end
        hold_v = nreset && tx_valid && !tx_ready;
        hold_d = tx_data;
        if (nreset && tx_valid && tx_ready) begin
            if (got_q.size() == 0) first_cyc = cyc;
            last_cyc = cyc;
            got_q.push_back(tx_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0; arm = 1'b0; smp_valid = 1'b0; tx_ready = 1'b0;
        tick(); tick();
    endtask

    task automatic send(input logic ch, input logic [15:0] d);
        smp_valid = 1'b1; smp_ch = ch; smp_data = d;
        tick();
        smp_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send(1'b0, l);
        send(1'b1, r);
    endtask

    task automatic exp_frame(input logic [15:0] l, input logic [15:0] r, input bit sync, input logic [7:0] stat);
        if (sync) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h5A);
            if (STAT_EN) exp_q.push_back(stat);
        end
        exp_q.push_back(l[15:8]); exp_q.push_back(l[7:0]);
        exp_q.push_back(r[15:8]); exp_q.push_back(r[7:0]);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic clear_q();
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        int nb;
        // Reset state and single frame latency.
        do_reset();
        check("rst_valid", tx_valid, 1'b0);
        check("rst_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_ovr", overrun_cnt, 8'h00);
        check("rst_level", fifo_level, 5'd0);
        nreset = 1'b1; arm = 1'b1; tx_ready = 1'b1;
        tick();
        clear_q();
        send(1'b0, 16'h1234);
        check("t1_pend_level", fifo_level, 5'd0);
        check("t1_pend_busy", busy, 1'b0);
        send(1'b1, 16'hABCD);
        check("t1_push_level", fifo_level, 5'd1);
        check("t1_push_valid", tx_valid, 1'b0);
        tick();
        check("t1_lat_valid", tx_valid, 1'b1);
        check("t1_lat_data", tx_data, 8'hA5);
        check("t1_pop_level", fifo_level, 5'd0);
        wait_idle(40, "t1");
        exp_frame(16'h1234, 16'hABCD, 1'b1, 8'h00);
        compare_q("t1");
        check("t1_end_level", fifo_level, 5'd0);

        // Sync every SI frames, back-to-back frames.
        do_reset();
        nreset = 1'b1; arm = 1'b1; tx_ready = 1'b1;
        tick();
        clear_q();
        for (int k = 0; k < 5; k++) send_frame(16'(k), 16'(k + 8));
        wait_idle(100, "t2");
        for (int k = 0; k < 5; k++) exp_frame(16'(k), 16'(k + 8), (k % 2) == 0, 8'h00);
        compare_q("t2");
        check("t2_no_gap", last_cyc - first_cyc + 1, got_q.size());

        // Overrun with a stalled UART, then saturation.
        do_reset();
        nreset = 1'b1; arm = 1'b1; tx_ready = 1'b0;
        tick();
        clear_q();
        for (int k = 0; k < 19; k++) send_frame(16'h1000 + 16'(k), 16'h2000 + 16'(k));
        check("t3_level_full", fifo_level, 5'd16);
        check("t3_ovr2", overrun_cnt, 8'd2);
        check("t3_held_valid", tx_valid, 1'b1);
        check("t3_held_data", tx_data, 8'hA5);
        for (int k = 0; k < 300; k++) send_frame(16'hEEEE, 16'(k));
        check("t3_ovr_sat", overrun_cnt, 8'd255);
        check("t3_level_still", fifo_level, 5'd16);
        tx_ready = 1'b1;
        wait_idle(400, "t3");
        for (int k = 0; k < 17; k++)
            exp_frame(16'h1000 + 16'(k), 16'h2000 + 16'(k), (k % 2) == 0, (k == 0) ? 8'h00 : 8'hFF);
        compare_q("t3");
        check("t3_ovr_kept", overrun_cnt, 8'd255);

        // arm low ignores strobes; right-first ordering; left overwrite.
        do_reset();
        nreset = 1'b1; arm = 1'b0; tx_ready = 1'b1;
        tick();
        clear_q();
        send_frame(16'h1111, 16'h2222);
        tick();
        check("t4_disarmed_level", fifo_level, 5'd0);
        check("t4_disarmed_busy", busy, 1'b0);
        arm = 1'b1;
        tick();
        send(1'b1, 16'h0001);
        send(1'b0, 16'h0002);
        send(1'b0, 16'h0003);
        send(1'b1, 16'h0004);
        wait_idle(40, "t4");
        exp_frame(16'h0003, 16'h0004, 1'b1, 8'h00);
        compare_q("t4");
        send(1'b0, 16'h5555);
        arm = 1'b0;
        tick();
        arm = 1'b1;
        tick();
        send(1'b1, 16'h6666);
        tick();
        check("t4_pend_cleared_level", fifo_level, 5'd0);
        check("t4_pend_cleared_busy", busy, 1'b0);

        // Backpressure: ready high one cycle in three.
        do_reset();
        nreset = 1'b1; arm = 1'b1; tx_ready = 1'b0;
        tick();
        clear_q();
        send_frame(16'hBEEF, 16'hCAFE);
        send_frame(16'h0102, 16'h0304);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tx_ready = ((n % 3) == 2);
            tick();
            n++;
        end
        check("t5_idle", busy, 1'b0);
        exp_frame(16'hBEEF, 16'hCAFE, 1'b1, 8'h00);
        exp_frame(16'h0102, 16'h0304, 1'b0, 8'h00);
        compare_q("t5");

        // Reset while sending LL with three frames queued.
        do_reset();
        nreset = 1'b1; arm = 1'b1; tx_ready = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) send_frame(16'h3000 + 16'(k), 16'h4000 + 16'(k));
        check("t6_level3", fifo_level, 5'd3);
        clear_q();
        nb = STAT_EN ? 4 : 3;
        tx_ready = 1'b1;
        n = 0;
        while (got_q.size() < nb && n < 40) begin
            tick();
            n++;
        end
        tx_ready = 1'b0;
        check("t6_reach_ll", got_q.size(), nb);
        if (got_q.size() >= nb) check("t6_lh_byte", got_q[nb-1], 8'h30);
        nreset = 1'b0;
        tick();
        check("t6_rst_valid", tx_valid, 1'b0);
        check("t6_rst_level", fifo_level, 5'd0);
        check("t6_rst_ovr", overrun_cnt, 8'h00);
        check("t6_rst_busy", busy, 1'b0);
        nreset = 1'b1; tx_ready = 1'b1;
        tick();
        clear_q();
        send_frame(16'h0A0B, 16'h0C0D);
        wait_idle(40, "t6");
        exp_frame(16'h0A0B, 16'h0C0D, 1'b1, 8'h00);
        compare_q("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
